store_buffer: RTL and testbench

Write-buffering front end for the data memory in the MEM stage. It accepts loads and stores from the EX/MEM pipeline register and queues stores in a small FIFO. It drains queued stores into `data_memory` whenever the memory port is not needed by a load. Loads go to `data_memory` immediately unless they hit a pending store, in which case the buffer either forwards the data or stalls the pipeline.

---
 rtl/store_buffer.sv | 169 ++++++++++++++++
 tb/tb_store_buffer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and data_memory: queues stores, drains them when the port is idle.
// Latency: loads 0 cycles (combinational), stores reach memory at the earliest one edge after acceptance.
// Backpressure: stall on load/pending-store overlap, on fence with stores pending, or on a store into a full queue with no drain.
// Optional feature: define STORE_BUFFER_FWD_EN to forward load data from a pending SW.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic        req_read,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        fence,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misaligned,
  output logic        empty,
  output logic        mem_write,
  output logic        mem_read,
  output logic [2:0]  funct3,
  output logic [31:0] addr,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Queue storage: one {addr, wdata, funct3} triple per entry
  logic [31:0]   entry_addr [DEPTH];
  logic [31:0]   entry_data [DEPTH];
  logic [2:0]    entry_f3   [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;

  logic          is_store;
  logic          is_load;
  logic          bad_align;
  logic          full;
  logic          hit;
  logic [AW-1:0] idx;
  logic          fwd_ok;
  logic [31:0]   fwd_data;
  logic          load_go;
  logic          load_mem;
  logic          load_fwd;
  logic          load_hazard;
  logic          store_go;
  logic          pop;
  logic          push;

  assign is_store  = req_valid & req_write;
  assign is_load   = req_valid & req_read;
  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned
  assign bad_align = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                     ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
  assign misaligned = (is_store | is_load) & bad_align;
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);

`ifdef STORE_BUFFER_FWD_EN
  logic [AW-1:0] young;

  // Pick the requested byte/halfword/word out of a stored word and extend it
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [2:0] f3);
    logic [31:0] s;
    s = w >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   extract = f3[2] ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      2'b01:   extract = f3[2] ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: extract = w;
    endcase
  endfunction
`endif

  // Word-granular overlap scan, oldest to youngest so the last match is the youngest
  always_comb begin
    hit = 1'b0;
    idx = '0;
`ifdef STORE_BUFFER_FWD_EN
    young = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if ((CW'(i) < count) && (entry_addr[idx][31:2] == req_addr[31:2])) begin
        hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        young = idx;
`endif
      end
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  // Only a full-word store is guaranteed to cover every byte the load can ask for
  assign fwd_ok   = hit & (entry_f3[young] == 3'b010);
  assign fwd_data = extract(entry_data[young], req_addr[1:0], req_funct3);
`else
  assign fwd_ok   = 1'b0;
  assign fwd_data = '0;
`endif

  // Request classification and port arbitration; loads win the memory port
  always_comb begin
    load_go     = is_load & ~bad_align;
    load_mem    = load_go & ~hit;
    load_fwd    = load_go & hit & fwd_ok;
    load_hazard = load_go & hit & ~fwd_ok;
    store_go    = is_store & ~bad_align;
    pop         = ~empty & ~load_mem;
    stall       = load_hazard | (fence & ~empty) | (store_go & full & ~pop);
    push        = store_go & ~stall;
  end

  // Memory port and load result; everything idles to zero when unused
  always_comb begin
    mem_write  = pop;
    mem_read   = load_mem;
    addr       = '0;
    funct3     = '0;
    write_data = '0;
    load_data  = '0;
    if (pop) begin
      addr       = entry_addr[head];
      funct3     = entry_f3[head];
      write_data = entry_data[head];
    end else if (load_mem) begin
      addr   = req_addr;
      funct3 = req_funct3;
    end
    if (load_mem) begin
      load_data = read_data;
    end else if (load_fwd) begin
      load_data = fwd_data;
    end
  end

  // Entry storage is written on accept; contents are don't-care until counted valid
  always_ff @(posedge clk) begin
    if (push) begin
      entry_addr[tail] <= req_addr;
      entry_data[tail] <= req_wdata;
      entry_f3[tail]   <= req_funct3;
    end
  end

  // Pointers and occupancy; reset discards anything still pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed scenarios plus random traffic against a queue-based model.
// Latency: checks each cycle on the falling edge; model state advances on the rising edge.
// Backpressure: a stalled request is held until stall drops, bounded by a cycle budget.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write, req_read, fence;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] load_data, addr, write_data, read_data;
  logic        stall, misaligned, empty, mem_write, mem_read;
  logic [2:0]  funct3;

  int checks = 0;
  int errors = 0;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_read(req_read), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .fence(fence), .load_data(load_data), .stall(stall),
    .misaligned(misaligned), .empty(empty), .mem_write(mem_write), .mem_read(mem_read),
    .funct3(funct3), .addr(addr), .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  // Extend a byte/half/word taken from a word at byte offset off
  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] off,
                                      input logic [2:0] f3);
    logic [31:0] s;
    s = w >> (8 * int'(off));
    case (f3)
      3'b000:  ext = {{24{s[7]}}, s[7:0]};
      3'b100:  ext = {24'h0, s[7:0]};
      3'b001:  ext = {{16{s[15]}}, s[15:0]};
      3'b101:  ext = {16'h0, s[15:0]};
      default: ext = w;
    endcase
  endfunction

  // data_memory stand-in: 1 KiB, combinational extended read, byte-lane write
  logic [7:0] pmem [1024];

  function automatic logic [31:0] pword(input logic [9:0] a);
    logic [9:0] b;
    b = {a[9:2], 2'b00};
    return {pmem[b + 10'd3], pmem[b + 10'd2], pmem[b + 10'd1], pmem[b]};
  endfunction

  always_comb read_data = ext(pword(addr[9:0]), addr[1:0], funct3);

  always @(posedge clk) begin
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: pmem[addr[9:0]] <= write_data[7:0];
        2'b01: begin
          pmem[addr[9:0]]         <= write_data[7:0];
          pmem[addr[9:0] + 10'd1] <= write_data[15:8];
        end
        default: begin
          pmem[{addr[9:2], 2'b00}] <= write_data[7:0];
          pmem[{addr[9:2], 2'b01}] <= write_data[15:8];
          pmem[{addr[9:2], 2'b10}] <= write_data[23:16];
          pmem[{addr[9:2], 2'b11}] <= write_data[31:24];
        end
      endcase
    end
  end

  // Reference model: committed bytes plus an ordered list of pending stores
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f3;
  } st_t;

  st_t        q[$];
  logic [7:0] cmem [1024];

  function automatic bit covers(input logic [2:0] f3, input int off, input int b);
    case (f3[1:0])
      2'b00:   return b == off;
      2'b01:   return (b / 2) == (off / 2);
      default: return 1'b1;
    endcase
  endfunction

  // Architectural word: committed memory overlaid with every pending store in program order
  function automatic logic [31:0] arch_word(input logic [31:0] a);
    logic [7:0]  by [4];
    logic [31:0] t;
    int          off;
    for (int b = 0; b < 4; b++) by[b] = cmem[{a[9:2], 2'(b)}];
    foreach (q[k]) begin
      if (q[k].a[31:2] == a[31:2]) begin
        off = int'(q[k].a[1:0]);
        for (int b = 0; b < 4; b++) begin
          if (covers(q[k].f3, off, b)) begin
            t = q[k].d >> (8 * (b - off));
            by[b] = t[7:0];
          end
        end
      end
    end
    return {by[3], by[2], by[1], by[0]};
  endfunction

  task automatic commit(input st_t e);
    logic [31:0] t;
    int          off;
    off = int'(e.a[1:0]);
    for (int b = 0; b < 4; b++) begin
      if (covers(e.f3, off, b)) begin
        t = e.d >> (8 * (b - off));
        cmem[{e.a[9:2], 2'(b)}] = t[7:0];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic        last_stall;
  logic [31:0] last_ldata;

  // One clock: predict from the model, compare on the falling edge, advance on the rising edge
  task automatic step();
    logic        e_mis, e_empty, ov, ld, st, fwd, e_mread, e_drain, e_stall;
    logic [2:0]  yf3;
    logic [31:0] e_ld;
    @(negedge clk);
    e_mis   = req_valid && (req_read || req_write) &&
              (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
    e_empty = (q.size() == 0);
    ov  = 1'b0;
    yf3 = 3'b000;
    foreach (q[k]) if (q[k].a[31:2] == req_addr[31:2]) begin ov = 1'b1; yf3 = q[k].f3; end
    ld = req_valid && req_read && !e_mis;
    st = req_valid && req_write && !e_mis;
`ifdef STORE_BUFFER_FWD_EN
    fwd = ld && ov && (yf3 == 3'b010);
`else
    fwd = 1'b0;
`endif
    e_mread = ld && !ov;
    e_drain = !e_empty && !e_mread;
    e_stall = (ld && ov && !fwd) || (fence && !e_empty) ||
              (st && (q.size() == DEPTH) && !e_drain);
    e_ld    = (e_mread || fwd) ? ext(arch_word(req_addr), req_addr[1:0], req_funct3) : 32'h0;
    chk("stall", {31'h0, stall}, {31'h0, e_stall});
    chk("misaligned", {31'h0, misaligned}, {31'h0, e_mis});
    chk("empty", {31'h0, empty}, {31'h0, e_empty});
    chk("mem_read", {31'h0, mem_read}, {31'h0, e_mread});
    chk("mem_write", {31'h0, mem_write}, {31'h0, e_drain});
    chk("load_data", load_data, e_ld);
    if (e_drain) begin
      chk("drain_addr", addr, q[0].a);
      chk("drain_data", write_data, q[0].d);
      chk("drain_f3", {29'h0, funct3}, {29'h0, q[0].f3});
    end else if (e_mread) begin
      chk("load_addr", addr, req_addr);
    end
    last_stall = stall;
    last_ldata = load_data;
    @(posedge clk);
    if (e_drain) begin
      commit(q[0]);
      void'(q.pop_front());
    end
    if (st && !e_stall) q.push_back('{a: req_addr, d: req_wdata, f3: req_funct3});
    #1;
  endtask

  // Present a request and hold it while stalled; n returns cycles to completion
  task automatic req(input logic v, input logic wr, input logic rd, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] d, input logic fe, output int n);
    req_valid  = v;
    req_write  = wr;
    req_read   = rd;
    req_funct3 = f;
    req_addr   = a;
    req_wdata  = d;
    fence      = fe;
    step();
    n = 1;
    while (last_stall && n < 40) begin
      step();
      n++;
    end
    chk("stall_bound", {31'h0, last_stall}, 32'h0);
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_write = 1'b0; req_read = 1'b0; fence = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    int          n;
    int          kind;
    logic [2:0]  f;
    logic [31:0] a;
    logic [2:0]  st_f3 [3] = '{3'b000, 3'b001, 3'b010};
    logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    for (int i = 0; i < 1024; i++) begin pmem[i] = 8'h0; cmem[i] = 8'h0; end
    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_misaligned", {31'h0, misaligned}, 32'h0);
    chk("rst_empty", {31'h0, empty}, 32'h1);
    chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
    chk("rst_mem_read", {31'h0, mem_read}, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_write_data", write_data, 32'h0);
    chk("rst_funct3", {29'h0, funct3}, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Store then load to a different word, then read the store back
    req(1, 1, 0, 3'b010, 32'h100, 32'h11223344, 0, n);
    req(1, 0, 1, 3'b010, 32'h200, 32'h0, 0, n);
    chk("diff_word_cycles", n, 1);
    idle_inputs();
    step();
    req(1, 0, 1, 3'b010, 32'h100, 32'h0, 0, n);
    chk("readback_sw", last_ldata, 32'h11223344);

    // Store hazard on a byte: one stall cycle then extended data
    req(1, 1, 0, 3'b000, 32'h200, 32'h000000AA, 0, n);
    req(1, 0, 1, 3'b000, 32'h200, 32'h0, 0, n);
    chk("hazard_cycles", n, 2);
    chk("hazard_lb", last_ldata, 32'hFFFFFFAA);
    req(1, 0, 1, 3'b100, 32'h200, 32'h0, 0, n);
    chk("hazard_lbu", last_ldata, 32'h000000AA);

    // Overlapping LH after SW: forwarded same cycle or stalled once
    req(1, 1, 0, 3'b010, 32'h104, 32'h80FF1234, 0, n);
    req(1, 0, 1, 3'b001, 32'h106, 32'h0, 0, n);
`ifdef STORE_BUFFER_FWD_EN
    chk("fwd_cycles", n, 1);
`else
    chk("fwd_cycles", n, 2);
`endif
    chk("fwd_lh", last_ldata, 32'hFFFF80FF);

    // Stores interleaved with loads to another word; memory ends up in order
    for (int i = 0; i < 5; i++) begin
      req(1, 1, 0, 3'b010, 32'(i * 4), 32'hA0000000 + 32'(i), 0, n);
      req(1, 0, 1, 3'b010, 32'h300, 32'h0, 0, n);
    end
    idle_inputs();
    req(0, 0, 0, 3'b000, 32'h0, 32'h0, 1, n);
    for (int i = 0; i < 5; i++) chk("full_order", pword(10'(i * 4)), 32'hA0000000 + 32'(i));

    // Misaligned accesses are dropped without memory traffic
    req(1, 0, 1, 3'b010, 32'h102, 32'h0, 0, n);
    chk("mis_lw_flag", {31'h0, misaligned}, 32'h1);
    req(1, 1, 0, 3'b001, 32'h1, 32'h5555, 0, n);
    idle_inputs();
    step();
    chk("mis_sh_dropped", pword(10'h0), 32'hA0000000);

    // Fence waits for the pending store to drain
    req(1, 1, 0, 3'b010, 32'h180, 32'hCAFEF00D, 0, n);
    req(0, 0, 0, 3'b000, 32'h0, 32'h0, 1, n);
    chk("fence_cycles", n, 2);
    chk("fence_mem", pword(10'h180), 32'hCAFEF00D);

    // Reset while a store is draining discards it
    req(1, 1, 0, 3'b010, 32'h40, 32'hDEADBEEF, 0, n);
    idle_inputs();
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_empty", {31'h0, empty}, 32'h1);
    chk("midrst_mem_write", {31'h0, mem_write}, 32'h0);
    chk("midrst_stall", {31'h0, stall}, 32'h0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_discard", pword(10'h40), 32'h0);

    // Random traffic over a small window so overlaps are frequent
    for (int r = 0; r < 400; r++) begin
      kind = $urandom_range(0, 9);
      a    = 32'h100 + {27'h0, 3'($urandom_range(0, 7)), 2'b00} + 32'($urandom_range(0, 3));
      if (kind <= 3) begin
        f = st_f3[$urandom_range(0, 2)];
        req(1, 1, 0, f, a, $urandom, 0, n);
      end else if (kind <= 7) begin
        f = ld_f3[$urandom_range(0, 4)];
        req(1, 0, 1, f, a, 32'h0, 0, n);
      end else if (kind == 8) begin
        req(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, n);
      end else begin
        req(0, 0, 0, 3'b000, 32'h0, 32'h0, 1, n);
      end
    end

    idle_inputs();
    req(0, 0, 0, 3'b000, 32'h0, 32'h0, 1, n);
    for (int w = 0; w < 256; w++) begin
      chk("final_mem", pword(10'(w * 4)),
          {cmem[w * 4 + 3], cmem[w * 4 + 2], cmem[w * 4 + 1], cmem[w * 4]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
